// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared cpu types and constants for the fetch stage
// Contents: fetch FSM state encoding, instruction/pc widths, pc step,
//           prefetch buffer entry layout, word alignment helper.
package cpu_pkg;

  localparam int          INSTR_WIDTH = 32;
  localparam int          PC_WIDTH    = 32;
  localparam logic [31:0] PC_STEP     = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } fetch_state_t;

  // One prefetch buffer entry: 64 bits, {pc, instr}
  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Clear the byte offset so every fetch address is word aligned
  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch buffer of {pc, instr} entries
// Ports: clk, rst_n (async active-low), i_push/i_push_data write side,
//        i_pop/o_pop_data read side (head visible combinationally),
//        i_flush empties the buffer, o_count/o_full/o_empty occupancy.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  fetch_entry_t  i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_pop_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  // A push into a full buffer is only accepted when the head leaves the same cycle
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - prefetching instruction fetch stage with redirect
// Ports: clk, rst_n (async active-low); run, stall, branch_valid/branch_target
//        control; mem_read/mem_addr/mem_ready/mem_rdata instruction memory;
//        instruction/pc_out/enable one-cycle strobe towards decode.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        enable
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t  r_state;
  fetch_state_t  w_next_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_redirect_pc;
  logic          r_discard;
  logic          r_enable;
  logic [31:0]   r_instruction;
  logic [31:0]   r_pc_out;

  logic          w_busy;
  logic          w_mem_done;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_after;
  logic          w_slot_after;
  logic          w_full;
  logic          w_empty;
  logic [31:0]   w_target;
  fetch_entry_t  w_push_data;
  fetch_entry_t  w_head;

  assign w_target   = word_align(branch_target);
  assign w_busy     = (r_state != ST_IDLE);
  assign w_mem_done = w_busy && mem_ready;
  // A word returning for a request overtaken by a branch is dropped
  assign w_push     = w_mem_done && !r_discard && !branch_valid;
  assign w_pop      = !w_empty && !stall && !branch_valid;

  // Occupancy after this edge; decides whether the next request may be issued
  assign w_count_after = branch_valid ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
  assign w_slot_after  = (w_count_after < CW'(FIFO_DEPTH));

  assign w_push_data.pc    = r_fetch_pc;
  assign w_push_data.instr = mem_rdata;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (branch_valid),
    .o_pop_data  (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        // Nothing outstanding here, so a free slot means the buffer is not full
        if (run && (branch_valid || !w_full)) w_next_state = ST_REQ;
      end
      ST_REQ, ST_WAIT: begin
        if (mem_ready) w_next_state = (run && w_slot_after) ? ST_REQ : ST_IDLE;
        else           w_next_state = ST_WAIT;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_read = (r_state == ST_REQ) || (r_state == ST_WAIT);
    mem_addr = r_fetch_pc;
  end

  // Fetch address and redirect bookkeeping. While a request is on the bus its
  // address must stay put, so a branch is parked in r_redirect_pc until the
  // stale word comes back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_redirect_pc <= RESET_PC;
      r_discard     <= 1'b0;
    end else if (w_mem_done) begin
      r_discard <= 1'b0;
      if (branch_valid)   r_fetch_pc <= w_target;
      else if (r_discard) r_fetch_pc <= r_redirect_pc;
      else                r_fetch_pc <= r_fetch_pc + PC_STEP;
    end else if (branch_valid) begin
      if (w_busy) begin
        r_redirect_pc <= w_target;
        r_discard     <= 1'b1;
      end else begin
        r_fetch_pc <= w_target;
      end
    end
  end

  // Decode strobe: instruction/pc_out hold their last value between pops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable      <= 1'b0;
      r_instruction <= '0;
      r_pc_out      <= '0;
    end else begin
      r_enable <= w_pop;
      if (w_pop) begin
        r_instruction <= w_head.instr;
        r_pc_out      <= w_head.pc;
      end
    end
  end

  assign enable      = r_enable;
  assign instruction = r_instruction;
  assign pc_out      = r_pc_out;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        enable;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .mem_read      (mem_read),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .instruction   (instruction),
    .pc_out        (pc_out),
    .enable        (enable)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  assign mem_rdata = instr_of(mem_addr);

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory model: each request waits a programmable number of cycles
  int          default_wait = 0;
  logic [31:0] slow_addr = 32'hFFFF_FFFF;
  int          slow_wait = 0;
  int          wcnt = 0;
  bit          busy = 0;
  bit          done_pending = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      busy = 0;
      wcnt = 0;
      mem_ready = 1'b0;
    end else begin
      if (done_pending) busy = 0;
      if (mem_read && !busy) begin
        busy = 1;
        wcnt = (mem_addr == slow_addr) ? slow_wait : default_wait;
      end else if (busy && wcnt > 0) begin
        wcnt--;
      end
      mem_ready = busy && (wcnt == 0);
    end
  end

  // Scoreboard: accepted words queued at transfer, compared at enable
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;
  sb_t         sb_q[$];
  logic [31:0] model_pc = 32'h0;
  logic [31:0] stale_addr = 32'h0;
  bit          stale = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      stale = 0;
      model_pc = 32'h0;
      done_pending = 0;
    end else begin
      if (enable) begin
        check("sb_nonempty_at_enable", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          sb_t e;
          e = sb_q.pop_front();
          check("sb_pc_out", pc_out, e.pc);
          check("sb_instruction", instruction, e.instr);
        end
      end
      done_pending = mem_read && mem_ready;
      if (mem_read) check("sb_mem_addr", mem_addr, stale ? stale_addr : model_pc);
      if (mem_read && mem_ready) begin
        if (!stale && !branch_valid) begin
          sb_q.push_back('{pc: model_pc, instr: instr_of(model_pc)});
          model_pc = model_pc + 32'd4;
        end
        stale = 0;
      end
      if (branch_valid) begin
        sb_q.delete();
        if (mem_read && !mem_ready) begin
          if (!stale) stale_addr = model_pc;
          stale = 1;
        end
        model_pc = branch_target & ~32'd3;
      end
    end
  end

  typedef struct {
    logic        run;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        rd;
    logic [31:0] addr;
    logic        en;
    logic [31:0] pc;
  } vec_t;
  vec_t vecs[19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    stall = 1'b0;
    branch_valid = 1'b0;
    branch_target = 32'h0;
    default_wait = 0;
    slow_addr = 32'hFFFF_FFFF;
    slow_wait = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Advance until mem_read is waiting at addr a (bounded)
  task automatic wait_pending(input logic [31:0] a, input string name);
    bit found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_read && mem_addr == a && !mem_ready) begin
        found = 1;
        break;
      end
      tick();
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic wait_enable(input logic [31:0] exp_pc, input string name);
    bit found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (enable) begin
        found = 1;
        break;
      end
      tick();
    end
    check({name, "_seen"}, 32'(found), 32'd1);
    if (found) check(name, pc_out, exp_pc);
  endtask

  initial begin
    // run stall br tgt | rd addr en pc
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h4};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h8};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h8};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h8};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h8};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h8};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h8};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h8};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'hC};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h10};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h18,  1'b0, 32'h10};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 32'h103, 1'b1, 32'h1C,  1'b1, 32'h14};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h14};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h14};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100};

    // Reset values
    tick();
    tick();
    @(negedge clk);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    tick();
    rst_n = 1'b1;

    // Streaming, stall with full buffer, branch coincident with mem_ready
    for (int i = 0; i < 19; i++) begin
      run = vecs[i].run;
      stall = vecs[i].stall;
      branch_valid = vecs[i].br;
      branch_target = vecs[i].tgt;
      @(negedge clk);
      check($sformatf("vec%0d_mem_read", i), 32'(mem_read), 32'(vecs[i].rd));
      if (vecs[i].rd) check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].addr);
      check($sformatf("vec%0d_enable", i), 32'(enable), 32'(vecs[i].en));
      check($sformatf("vec%0d_pc_out", i), pc_out, vecs[i].pc);
      tick();
    end
    branch_valid = 1'b0;

    // Memory wait of 3 cycles at address 8
    begin
      int n_hold = 0;
      int ready_cyc = -1;
      int en_cyc = -1;
      do_reset();
      slow_addr = 32'h8;
      slow_wait = 3;
      run = 1'b1;
      for (int i = 0; i < 14; i++) begin
        @(negedge clk);
        if (mem_read && mem_addr == 32'h8) n_hold++;
        if (mem_read && mem_addr == 32'h8 && mem_ready) ready_cyc = i;
        if (enable && pc_out == 32'h8) en_cyc = i;
        tick();
      end
      check("wait_hold_cycles", 32'(n_hold), 32'd4);
      check("wait_ready_cycle", 32'(ready_cyc), 32'd6);
      check("wait_enable_cycle", 32'(en_cyc), 32'd8);
    end

    // Branch during WAIT: stale word dropped, next request at aligned target
    begin
      int bad = 0;
      bit found = 0;
      do_reset();
      slow_addr = 32'h8;
      slow_wait = 3;
      run = 1'b1;
      wait_pending(32'h8, "bwait_pending");
      tick();
      branch_valid = 1'b1;
      branch_target = 32'h0000_0103;
      tick();
      branch_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (enable && pc_out == 32'h8) bad++;
        if (mem_read && mem_addr != 32'h8) begin
          found = 1;
          break;
        end
        tick();
      end
      check("bwait_new_req_seen", 32'(found), 32'd1);
      check("bwait_next_addr", mem_addr, 32'h0000_0100);
      check("bwait_stale_enables", 32'(bad), 32'd0);
      tick();
      wait_enable(32'h0000_0100, "bwait_first_enable");
      tick();
    end

    // fetch_pc wraps from 0xFFFF_FFFC to 0
    begin
      logic [31:0] exp_pcs[4];
      int n = 0;
      exp_pcs[0] = 32'hFFFF_FFF8;
      exp_pcs[1] = 32'hFFFF_FFFC;
      exp_pcs[2] = 32'h0000_0000;
      exp_pcs[3] = 32'h0000_0004;
      do_reset();
      run = 1'b1;
      tick();
      branch_valid = 1'b1;
      branch_target = 32'hFFFF_FFF8;
      tick();
      branch_valid = 1'b0;
      for (int i = 0; i < 30 && n < 4; i++) begin
        @(negedge clk);
        if (enable) begin
          check($sformatf("wrap_pc%0d", n), pc_out, exp_pcs[n]);
          n++;
        end
        tick();
      end
      check("wrap_enable_count", 32'(n), 32'd4);
    end

    // run dropped while waiting: outstanding word still delivered, no new request
    begin
      int extra = 0;
      int en8 = 0;
      do_reset();
      slow_addr = 32'h8;
      slow_wait = 2;
      run = 1'b1;
      wait_pending(32'h8, "run0_pending");
      tick();
      run = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (mem_read && mem_addr != 32'h8) extra++;
        if (enable && pc_out == 32'h8) en8++;
        tick();
      end
      check("run0_new_requests", 32'(extra), 32'd0);
      check("run0_enable_pc8", 32'(en8), 32'd1);
    end

    // Asynchronous reset mid-WAIT with one buffered entry
    begin
      bit found = 0;
      do_reset();
      slow_addr = 32'h10;
      slow_wait = 5;
      run = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (mem_read && mem_addr == 32'hC) begin
          found = 1;
          break;
        end
        tick();
      end
      check("arst_reach_addr12", 32'(found), 32'd1);
      tick();
      stall = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check("arst_pre_mem_read", 32'(mem_read), 32'd1);
      check("arst_pre_mem_addr", mem_addr, 32'h10);
      check("arst_pre_pc_out", pc_out, 32'h8);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_mem_read", 32'(mem_read), 32'd0);
      check("arst_mem_addr", mem_addr, 32'h0);
      check("arst_enable", 32'(enable), 32'd0);
      check("arst_instruction", instruction, 32'h0);
      check("arst_pc_out", pc_out, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      stall = 1'b0;
      slow_addr = 32'hFFFF_FFFF;
      found = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (mem_read) begin
          found = 1;
          break;
        end
        tick();
      end
      check("arst_restart_seen", 32'(found), 32'd1);
      check("arst_restart_addr", mem_addr, 32'h0);
      tick();
      wait_enable(32'h0, "arst_first_enable");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
